// File: rtl/writeback_unit.sv
// writeback_unit
//   Writeback stage: buffers register-write results from execute in a small
//   FIFO and delivers them one at a time to the register bank using a
//   two-phase toggle strobe. Writes to r15 become a PC load for fetch and
//   never reach the bank. Exposes a per-register pending mask for RAW stalls.
//
//   Optional build macro: WRITEBACK_FWD_EN enables the forwarding port
//   (youngest pending value for fwdAddr). Without it fwdHit/fwdData are 0.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   HOLD_CYCLES  cycles addrw/dataOut stay stable after a toggle (>= 1)
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   inValid/inAddr/inData  write from execute; inReady = FIFO not full
//   triggerOutw            toggle strobe, one toggle per bank write
//   addrw/dataOut          bank write address/data
//   pcLoad/pcTarget        one-cycle PC load pulse and target
//   pendingMask            bit n set while a write to rn is queued/in flight
//   busy                   FIFO non-empty or FSM not idle
//   fwdAddr/fwdHit/fwdData forwarding query and result
module writeback_unit #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  input  logic [3:0]  inAddr,
  input  logic [31:0] inData,
  output logic        inReady,
  output logic        triggerOutw,
  output logic [3:0]  addrw,
  output logic [31:0] dataOut,
  output logic        pcLoad,
  output logic [31:0] pcTarget,
  output logic [15:0] pendingMask,
  output logic        busy,
  input  logic [3:0]  fwdAddr,
  output logic        fwdHit,
  output logic [31:0] fwdData
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  typedef logic [HW-1:0] hcnt_t;
  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;

  logic [3:0]  mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];
  ptr_t        head, tail;
  cnt_t        count;
  logic [DEPTH-1:0] valid;

  state_t      state, state_nx;
  hcnt_t       holdCnt, holdCnt_nx;
  logic [3:0]  ifAddr;
  logic [31:0] ifData;

  logic push, pop, do_toggle, do_pcload;

  // inReady uses the pre-pop count, so a full FIFO refuses even while popping
  assign inReady = (count != cnt_t'(DEPTH));
  assign push    = inValid & inReady;
  assign busy    = (count != '0) || (state != IDLE);

  always_comb begin
    state_nx   = state;
    holdCnt_nx = holdCnt;
    pop        = 1'b0;
    do_toggle  = 1'b0;
    do_pcload  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          state_nx = LAUNCH;
        end
      end
      LAUNCH: begin
        if (ifAddr == 4'd15) begin
          do_pcload = 1'b1;
          state_nx  = IDLE;
        end else begin
          do_toggle  = 1'b1;
          holdCnt_nx = hcnt_t'(HOLD_CYCLES - 1);
          state_nx   = HOLD;
        end
      end
      HOLD: begin
        if (holdCnt == '0) state_nx = IDLE;
        else               holdCnt_nx = holdCnt - hcnt_t'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      holdCnt <= '0;
    end else begin
      state   <= state_nx;
      holdCnt <= holdCnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + ptr_t'(1);
      if (pop)  head <= head + ptr_t'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: only entries flagged by 'valid' are ever observed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= inAddr;
      mem_data[tail] <= inData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifAddr      <= '0;
      ifData      <= '0;
      addrw       <= '0;
      dataOut     <= '0;
      triggerOutw <= 1'b0;
      pcLoad      <= 1'b0;
      pcTarget    <= '0;
    end else begin
      pcLoad <= do_pcload;
      if (pop) begin
        ifAddr <= mem_addr[head];
        ifData <= mem_data[head];
        // bank address/data move only here, one cycle ahead of the toggle
        if (mem_addr[head] != 4'd15) begin
          addrw   <= mem_addr[head];
          dataOut <= mem_data[head];
        end
      end
      if (do_toggle) triggerOutw <= ~triggerOutw;
      if (do_pcload) pcTarget <= ifData;
    end
  end

  // Entry i is live when its distance from head is below count
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      valid[i] = ({1'b0, ptr_t'(i) - head} < count);
  end

  always_comb begin
    pendingMask = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (valid[i]) pendingMask[mem_addr[i]] = 1'b1;
    if (state != IDLE) pendingMask[ifAddr] = 1'b1;
  end

`ifdef WRITEBACK_FWD_EN
  ptr_t fidx;

  // Oldest-first scan with overwrite, so the youngest match ends up winning;
  // the in-flight entry is older than anything in the FIFO.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    fidx    = '0;
    if ((state != IDLE) && (ifAddr == fwdAddr)) begin
      fwdHit  = 1'b1;
      fwdData = ifData;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fidx = head + ptr_t'(k);
      if (({1'b0, ptr_t'(k)} < count) && (mem_addr[fidx] == fwdAddr)) begin
        fwdHit  = 1'b1;
        fwdData = mem_data[fidx];
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^fwdAddr;
  assign fwdHit     = 1'b0;
  assign fwdData    = '0;
`endif

endmodule
